// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding and defaults for the FIFO round-robin arbiter
package fifo_arb_pkg;

  localparam int STATE_W       = 3;
  localparam int NUM_FIFOS_DEF = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/fifo_rr_pick.sv
// rtl/fifo_rr_pick.sv - combinational source picker; round-robin after last, or fixed
// lowest-index priority when ARB_STRICT_PRIO_EN is defined
module fifo_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick_oh,
  output logic [IW-1:0] pick_idx,
  output logic          pick_valid
);

  logic [IW-1:0] cand;

  always_comb begin
    pick_oh    = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    cand       = last;
`ifdef ARB_STRICT_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_idx   = IW'(i);
        pick_valid = 1'b1;
      end
    end
`else
    // Scan from farthest to nearest so the nearest requester after last wins.
    for (int k = N; k >= 1; k--) begin
      cand = last + IW'(k);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
`endif
    if (pick_valid) pick_oh[pick_idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - shares one downstream FIFO write port between NUM_FIFOS sources;
// arbitration mode selected by ARB_STRICT_PRIO_EN (see fifo_rr_pick)
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BITNUMBER = 8,
  parameter int NUM_FIFOS = NUM_FIFOS_DEF,
  parameter int LENGTH    = 8,
  parameter int THR_W     = $clog2(LENGTH) + 1,
  localparam int GW       = $clog2(NUM_FIFOS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           init,
  input  logic [THR_W-1:0]               umbral_af_in,
  output logic [THR_W-1:0]               umbral_af,
  input  logic [NUM_FIFOS-1:0]           fifo_empty,
  input  logic [NUM_FIFOS*BITNUMBER-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]           fifo_rd,
  input  logic                           pause,
  input  logic                           dst_full,
  output logic                           out_wr,
  output logic [BITNUMBER-1:0]           out_data,
  output logic [GW-1:0]                  grant,
  output logic [STATE_W-1:0]             state,
  output logic                           idle,
  output logic                           error
);

  state_t               st, st_nxt;
  logic                 data_vld;
  logic [NUM_FIFOS-1:0] pick_oh;
  logic [GW-1:0]        pick_idx;
  logic                 pick_valid;
  logic                 err_det;
  logic                 all_empty;
  logic                 rd_en;

  fifo_rr_pick #(.N(NUM_FIFOS), .IW(GW)) u_pick (
    .req       (~fifo_empty),
    .last      (grant),
    .pick_oh   (pick_oh),
    .pick_idx  (pick_idx),
    .pick_valid(pick_valid)
  );

  assign state     = st;
  assign err_det   = out_wr && dst_full;
  assign all_empty = &fifo_empty;
  // Read strobe is decoded from the current empty flags, so a source popped this
  // cycle shows its updated flag before it can be strobed again.
  assign rd_en     = (st == ST_ACTIVE) && !pause && !init && pick_valid && !err_det;
  assign fifo_rd   = rd_en ? pick_oh : '0;

  always_comb begin
    st_nxt = st;
    if (err_det) begin
      st_nxt = ST_ERROR;
    end else begin
      case (st)
        ST_RESET:  st_nxt = ST_INIT;
        ST_INIT:   if (!init) st_nxt = all_empty ? ST_IDLE : ST_ACTIVE;
        ST_IDLE: begin
          if (init) st_nxt = ST_INIT;
          else if (!all_empty) st_nxt = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          // The write leaving this cycle completes on its own; only a word still
          // coming out of a source keeps the FSM here.
          if (!data_vld) begin
            if (init) st_nxt = ST_INIT;
            else if (all_empty) st_nxt = ST_IDLE;
          end
        end
        ST_ERROR:  if (init) st_nxt = ST_INIT;
        default:   st_nxt = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= ST_RESET;
      idle      <= 1'b0;
      error     <= 1'b0;
      umbral_af <= '0;
      grant     <= GW'(NUM_FIFOS - 1);
      data_vld  <= 1'b0;
      out_wr    <= 1'b0;
      out_data  <= '0;
    end else begin
      st    <= st_nxt;
      idle  <= (st_nxt == ST_IDLE);
      error <= (st_nxt == ST_ERROR);
      if (st == ST_INIT) umbral_af <= umbral_af_in;
      if (rd_en) grant <= pick_idx;
      if (err_det || st == ST_ERROR) begin
        data_vld <= 1'b0;
        out_wr   <= 1'b0;
      end else begin
        data_vld <= rd_en;
        out_wr   <= data_vld;
        if (data_vld) out_data <= fifo_data[grant*BITNUMBER +: BITNUMBER];
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - directed self-checking bench for fifo_rr_arbiter
module tb_fifo_rr_arbiter;

  localparam int NF = 4;
  localparam int BW = 8;
  localparam int TW = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           init;
  logic [TW-1:0]  umbral_af_in;
  logic [TW-1:0]  umbral_af;
  logic [NF-1:0]  fifo_empty;
  logic [NF*BW-1:0] fifo_data;
  logic [NF-1:0]  fifo_rd;
  logic           pause;
  logic           dst_full;
  logic           out_wr;
  logic [BW-1:0]  out_data;
  logic [1:0]     grant;
  logic [2:0]     state;
  logic           idle;
  logic           error;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int bad_rd = 0;

  logic [BW-1:0] mem [NF][32];
  int            wp [NF];
  int            rp [NF];
  logic [BW-1:0] rdata [NF];

  int            rd_cyc[$];
  logic [NF-1:0] rd_val[$];
  int            wr_cyc[$];
  logic [BW-1:0] wr_val[$];
  int            idle_cyc[$];
  logic          idle_prev = 1'b0;

  fifo_rr_arbiter #(.BITNUMBER(BW), .NUM_FIFOS(NF), .LENGTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .init        (init),
    .umbral_af_in(umbral_af_in),
    .umbral_af   (umbral_af),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd     (fifo_rd),
    .pause       (pause),
    .dst_full    (dst_full),
    .out_wr      (out_wr),
    .out_data    (out_data),
    .grant       (grant),
    .state       (state),
    .idle        (idle),
    .error       (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Source FIFO models: registered read data, valid the cycle after the strobe.
  always @(posedge clk) begin
    for (int i = 0; i < NF; i++) begin
      if (fifo_rd[i]) begin
        if (wp[i] == rp[i]) bad_rd <= bad_rd + 1;
        else begin
          rdata[i] <= mem[i][rp[i]];
          rp[i]    <= rp[i] + 1;
        end
      end
    end
  end

  always_comb begin
    fifo_empty = '0;
    fifo_data  = '0;
    for (int i = 0; i < NF; i++) begin
      fifo_empty[i]         = (wp[i] == rp[i]);
      fifo_data[i*BW +: BW] = rdata[i];
    end
  end

  always @(negedge clk) begin
    if (fifo_rd != 0) begin
      rd_cyc.push_back(cyc);
      rd_val.push_back(fifo_rd);
    end
    if (out_wr) begin
      wr_cyc.push_back(cyc);
      wr_val.push_back(out_data);
    end
    if (idle && !idle_prev) idle_cyc.push_back(cyc);
    idle_prev <= idle;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int f, input logic [BW-1:0] d);
    mem[f][wp[f]] = d;
    wp[f] = wp[f] + 1;
  endtask

  task automatic test_reset();
    reset = 1'b0; init = 1'b1; umbral_af_in = 4'd6; pause = 1'b0; dst_full = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL reset_state got %0d want 0", state); end
    tests++; if (fifo_rd !== 4'd0 || out_wr !== 1'b0 || out_data !== 8'd0) begin fails++; $display("FAIL reset_outs rd=%b wr=%b data=%h want 0", fifo_rd, out_wr, out_data); end
    tests++; if (grant !== 2'd3) begin fails++; $display("FAIL reset_grant got %0d want 3", grant); end
    tests++; if (umbral_af !== 4'd0 || idle !== 1'b0 || error !== 1'b0) begin fails++; $display("FAIL reset_flags thr=%0d idle=%b err=%b want 0", umbral_af, idle, error); end
    step();
    reset = 1'b1;
    @(negedge clk);
    tests++; if (state !== 3'd0) begin fails++; $display("FAIL release_state got %0d want 0", state); end
    step();
    tests++; if (state !== 3'd1 || umbral_af !== 4'd0) begin fails++; $display("FAIL init_entry state=%0d thr=%0d want 1/0", state, umbral_af); end
    step();
    tests++; if (umbral_af !== 4'd6) begin fails++; $display("FAIL init_thr got %0d want 6", umbral_af); end
    init = 1'b0;
    step();
    tests++; if (state !== 3'd2 || idle !== 1'b1) begin fails++; $display("FAIL init_to_idle state=%0d idle=%b want 2/1", state, idle); end
  endtask

  task automatic test_round_robin();
    logic [NF-1:0] er [8];
    logic [BW-1:0] ed [8];
    int c0, nr, nw, ni;
`ifdef ARB_STRICT_PRIO_EN
    er = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    ed = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1};
`else
    er = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    ed = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
`endif
    pause = 1'b1;
    push(0, 8'hA0); push(0, 8'hA1); push(1, 8'hB0); push(1, 8'hB1);
    push(2, 8'hC0); push(2, 8'hC1); push(3, 8'hD0); push(3, 8'hD1);
    for (int i = 0; i < 10 && state !== 3'd3; i++) step();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL rr_active state=%0d want 3", state); end
    nr = rd_cyc.size(); nw = wr_cyc.size(); ni = idle_cyc.size();
    c0 = cyc;
    pause = 1'b0;
    repeat (14) step();
    tests++; if (rd_cyc.size() - nr !== 8 || wr_cyc.size() - nw !== 8) begin fails++; $display("FAIL rr_counts rd=%0d wr=%0d want 8/8", rd_cyc.size() - nr, wr_cyc.size() - nw); end
    for (int k = 0; k < 8 && nr + k < rd_cyc.size(); k++) begin
      tests++; if (rd_val[nr+k] !== er[k] || rd_cyc[nr+k] !== c0 + k) begin fails++; $display("FAIL rr_rd%0d got %b@%0d want %b@%0d", k, rd_val[nr+k], rd_cyc[nr+k] - c0, er[k], k); end
    end
    for (int k = 0; k < 8 && nw + k < wr_cyc.size(); k++) begin
      tests++; if (wr_val[nw+k] !== ed[k] || wr_cyc[nw+k] !== c0 + k + 2) begin fails++; $display("FAIL rr_wr%0d got %h@%0d want %h@%0d", k, wr_val[nw+k], wr_cyc[nw+k] - c0, ed[k], k + 2); end
    end
    tests++; if (idle_cyc.size() != ni + 1 || idle_cyc[idle_cyc.size()-1] !== c0 + 10) begin fails++; $display("FAIL drain_idle rises=%0d at %0d want 1 at 10", idle_cyc.size() - ni, idle_cyc[idle_cyc.size()-1] - c0); end
    tests++; if (grant !== 2'd3) begin fails++; $display("FAIL rr_grant got %0d want 3", grant); end
  endtask

  task automatic test_skip_wrap();
    logic [NF-1:0] er [4];
    logic [BW-1:0] ed [4];
    int c0, nr, nw;
`ifdef ARB_STRICT_PRIO_EN
    er = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
    ed = '{8'hB2, 8'hB3, 8'hD2, 8'hD3};
`else
    er = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    ed = '{8'hB2, 8'hD2, 8'hB3, 8'hD3};
`endif
    pause = 1'b1;
    push(1, 8'hB2); push(1, 8'hB3); push(3, 8'hD2); push(3, 8'hD3);
    for (int i = 0; i < 10 && state !== 3'd3; i++) step();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL skip_active state=%0d want 3", state); end
    nr = rd_cyc.size(); nw = wr_cyc.size();
    c0 = cyc;
    pause = 1'b0;
    repeat (10) step();
    tests++; if (rd_cyc.size() - nr !== 4 || wr_cyc.size() - nw !== 4) begin fails++; $display("FAIL skip_counts rd=%0d wr=%0d want 4/4", rd_cyc.size() - nr, wr_cyc.size() - nw); end
    for (int k = 0; k < 4 && nr + k < rd_cyc.size(); k++) begin
      tests++; if (rd_val[nr+k] !== er[k] || rd_cyc[nr+k] !== c0 + k) begin fails++; $display("FAIL skip_rd%0d got %b@%0d want %b@%0d", k, rd_val[nr+k], rd_cyc[nr+k] - c0, er[k], k); end
    end
    for (int k = 0; k < 4 && nw + k < wr_cyc.size(); k++) begin
      tests++; if (wr_val[nw+k] !== ed[k]) begin fails++; $display("FAIL skip_wr%0d got %h want %h", k, wr_val[nw+k], ed[k]); end
    end
    tests++; if (state !== 3'd2) begin fails++; $display("FAIL skip_idle state=%0d want 2", state); end
  endtask

  task automatic test_pause();
    int ec [6];
    int c0, nr, nw;
    ec = '{0, 1, 2, 8, 9, 10};
    pause = 1'b1;
    for (int k = 0; k < 6; k++) push(0, 8'h10 + 8'(k));
    for (int i = 0; i < 10 && state !== 3'd3; i++) step();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL pause_active state=%0d want 3", state); end
    nr = rd_cyc.size(); nw = wr_cyc.size();
    c0 = cyc;
    pause = 1'b0;
    repeat (3) step();
    pause = 1'b1;
    repeat (5) step();
    pause = 1'b0;
    repeat (8) step();
    tests++; if (rd_cyc.size() - nr !== 6 || wr_cyc.size() - nw !== 6) begin fails++; $display("FAIL pause_counts rd=%0d wr=%0d want 6/6", rd_cyc.size() - nr, wr_cyc.size() - nw); end
    for (int k = 0; k < 6 && nr + k < rd_cyc.size(); k++) begin
      tests++; if (rd_val[nr+k] !== 4'b0001 || rd_cyc[nr+k] !== c0 + ec[k]) begin fails++; $display("FAIL pause_rd%0d got %b@%0d want 0001@%0d", k, rd_val[nr+k], rd_cyc[nr+k] - c0, ec[k]); end
    end
    for (int k = 0; k < 6 && nw + k < wr_cyc.size(); k++) begin
      tests++; if (wr_val[nw+k] !== 8'h10 + 8'(k) || wr_cyc[nw+k] !== c0 + ec[k] + 2) begin fails++; $display("FAIL pause_wr%0d got %h@%0d want %h@%0d", k, wr_val[nw+k], wr_cyc[nw+k] - c0, 8'h10 + 8'(k), ec[k] + 2); end
    end
  endtask

  task automatic test_error();
    int nr, nw;
    pause = 1'b1;
    push(2, 8'hE0); push(2, 8'hE1); push(2, 8'hE2); push(2, 8'hE3);
    for (int i = 0; i < 10 && state !== 3'd3; i++) step();
    tests++; if (state !== 3'd3) begin fails++; $display("FAIL err_active state=%0d want 3", state); end
    nr = rd_cyc.size(); nw = wr_cyc.size();
    pause = 1'b0;
    repeat (2) step();
    dst_full = 1'b1;
    step();
    dst_full = 1'b0;
    @(negedge clk);
    tests++; if (state !== 3'd4 || error !== 1'b1) begin fails++; $display("FAIL err_enter state=%0d err=%b want 4/1", state, error); end
    tests++; if (out_wr !== 1'b0 || fifo_rd !== 4'd0) begin fails++; $display("FAIL err_quiet wr=%b rd=%b want 0/0000", out_wr, fifo_rd); end
    repeat (3) step();
    tests++; if (rd_cyc.size() - nr !== 2 || wr_cyc.size() - nw !== 1) begin fails++; $display("FAIL err_traffic rd=%0d wr=%0d want 2/1", rd_cyc.size() - nr, wr_cyc.size() - nw); end
    tests++; if (state !== 3'd4) begin fails++; $display("FAIL err_sticky state=%0d want 4", state); end
    init = 1'b1;
    step();
    tests++; if (state !== 3'd1 || error !== 1'b0) begin fails++; $display("FAIL err_to_init state=%0d err=%b want 1/0", state, error); end
    init = 1'b0;
    nw = wr_cyc.size();
    step();
    for (int i = 0; i < 30 && idle !== 1'b1; i++) step();
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL err_recover_idle timeout state=%0d", state); end
    tests++; if (wr_cyc.size() - nw !== 2 || wr_val[nw] !== 8'hE2 || wr_val[nw+1] !== 8'hE3) begin fails++; $display("FAIL err_recover_data count=%0d want 2 words E2,E3", wr_cyc.size() - nw); end
    tests++; if (bad_rd !== 0) begin fails++; $display("FAIL empty_strobes got %0d want 0", bad_rd); end
  endtask

  initial begin
    for (int i = 0; i < NF; i++) begin
      wp[i] = 0; rp[i] = 0; rdata[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_pause();
    test_error();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Controller that shares one downstream FIFO write port between NUM_FIFOS source FIFOs.
- It sequences reads from the sources round-robin, forwards each word downstream, and honours the downstream pause (almost-full) backpressure.
- It also owns the configuration of the source FIFOs: the almost-full threshold is latched in INIT and distributed.
- Its FSM status outputs go to the top-level controller.

Parameters:
- BITNUMBER, 8, data word width.
- NUM_FIFOS, 4, number of source FIFOs (power of two, 2..8).
- LENGTH, 8, depth of each source FIFO.
- THR_W, $clog2(LENGTH)+1, threshold width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- init  in  1  level; while high the FSM stays in INIT and reloads configuration.
- umbral_af_in  in  THR_W  almost-full threshold to program.
- umbral_af  out  THR_W  latched threshold driven to all source FIFOs.
- fifo_empty  in  NUM_FIFOS  per-source empty flag (bit i = FIFO i).
- fifo_data  in  NUM_FIFOS*BITNUMBER  per-source read data, FIFO i at [i*BITNUMBER +: BITNUMBER].
- fifo_rd  out  NUM_FIFOS  one-hot read strobe.
- pause  in  1  downstream almost-full; stops new reads.
- dst_full  in  1  downstream full.
- out_wr  out  1  downstream write strobe.
- out_data  out  BITNUMBER  downstream write data.
- grant  out  $clog2(NUM_FIFOS)  index of the last FIFO read.
- state  out  3  FSM state encoding.
- idle  out  1  high in IDLE.
- error  out  1  high in ERROR.

Behaviour:
- Reset (reset=0, async):
  - outputs: fifo_rd=0, out_wr=0, out_data=0, grant=NUM_FIFOS-1 (so FIFO 0 is first), umbral_af=0, state=RESET, idle=0, error=0.
  - in-flight pipeline flags are cleared.
- FSM encodings: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
  - RESET -> INIT on the first clk after reset release.
  - INIT:
    - umbral_af <= umbral_af_in every cycle.
    - No reads are issued.
    - Exits when init=0: to IDLE if all fifo_empty=1, else ACTIVE.
  - IDLE:
    - idle=1.
    - -> ACTIVE when any fifo_empty bit is 0.
    - -> INIT when init=1.
  - ACTIVE:
    - arbitration runs.
    - -> IDLE when all sources are empty and the pipeline has drained (no read or write in flight).
    - -> INIT when init=1; this takes effect only after the pipeline drains, and no new reads are issued meanwhile.
  - ERROR:
    - error=1, no reads, out_wr=0.
    - Sticky; exits only by reset, or by init=1 -> INIT.
- Error detection: out_wr=1 while dst_full=1, in any state, -> ERROR next cycle. The offending word is discarded.
- Arbitration, ACTIVE only:
  - At most one read per cycle.
  - Candidates are FIFOs with fifo_empty=0.
  - Search starts at grant+1 and wraps modulo NUM_FIFOS.
  - The selected FIFO gets fifo_rd high for one cycle, and grant updates to that index on the same edge.
  - No read is issued when pause=1, when no candidate exists, or in any state other than ACTIVE.
  - Never strobe an empty FIFO.
- Latency (read issued in cycle t):
  - Source data is valid in cycle t+1.
  - The arbiter registers it, so out_wr=1 and out_data=word in cycle t+2.
  - Back-to-back reads give one word per cycle.
- Pause:
  - pause is sampled each cycle.
  - Words already in flight (up to 2) are still written.
  - The downstream threshold must leave at least 2 free entries.
  - Reads resume in the first cycle pause=0.
- Simultaneous events, priority: reset > ERROR detection > init > normal.
- Reading and writing in the same cycle is normal pipelined operation.

Optional Feature:
- Macro ARB_STRICT_PRIO_EN.
- Defined: fixed priority; the lowest-index non-empty FIFO always wins, and grant is still updated for observation.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package fifo_arb_pkg holds:
  - state encoding constants (RESET..ERROR) and the state width of 3;
  - the default NUM_FIFOS.
- One natural sub-module, fifo_rr_pick:
  - combinational;
  - inputs: request vector (~fifo_empty) and last grant;
  - outputs: one-hot pick, pick index and valid.
  - It also contains the ARB_STRICT_PRIO_EN variant.
- The FSM and pipeline registers stay in fifo_rr_arbiter.

Test Plan:
- Reset/INIT: hold reset=0 for 2 clk, release with init=1, umbral_af_in=6, then init=0 with all FIFOs empty. Required:
  - state goes RESET -> INIT -> IDLE;
  - umbral_af=6;
  - all outputs 0 during reset.
- Round-robin: FIFOs 0..3 preloaded with 'hA0.., 'hB0.., 'hC0.., 'hD0... Required:
  - fifo_rd sequence 0001, 0010, 0100, 1000, 0001;
  - out_data A0, B0, C0, D0, A1, starting 2 cycles after the first read.
- Skip and wrap: only FIFOs 1 and 3 non-empty, grant=3. Required: reads alternate 1, 3, 1, 3; FIFOs 0 and 2 are never strobed.
- Pause: assert pause for 5 cycles mid-stream. Required:
  - no fifo_rd from the cycle after pause is sampled;
  - exactly the 2 in-flight words are written;
  - reads resume the cycle pause drops, with no word lost or duplicated.
- Error: force dst_full=1 while out_wr=1. Required:
  - state=ERROR and error=1 next cycle;
  - no further reads;
  - init=1 returns the FSM to INIT with error=0.
- Drain to IDLE: empty all sources. Required: idle=1 exactly one cycle after the last out_wr; with ARB_STRICT_PRIO_EN defined, FIFO 0 is always drained first.
